i2c_target_rx: RTL and testbench
================================

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 SHALL have parameter ADDR, default 7'h3C, the 7-bit target address it answers.
REQ-002 SHALL have parameter MIN_PHASE, default 4, the minimum SCL high/low time in clk cycles that the block must support.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 scl  input  1  raw I2C SCL from the pin, asynchronous to clk.
REQ-006 sda  input  1  raw I2C SDA from the pin, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain ACK); 0 = release.
REQ-008 byte_valid  output  1  one-clk pulse; byte_data and byte_dcn are valid.
REQ-009 byte_data  output  8  received payload byte, MSB first on the wire; holds until the next pulse.
REQ-010 byte_dcn  output  1  0 = command byte, 1 = display data; qualified by byte_valid.
REQ-011 busy  output  1  high from the address-match ACK until STOP, repeated START, or reset.
REQ-012 frame_end  output  1  one-clk pulse on a STOP that ends an addressed transaction.

Function
REQ-013 SHALL pass scl and sda through 2-flop synchronizers, then a third history flop; all edges come from the synchronized signals.
REQ-014 Edge latency SHALL be fixed: a pin change becomes a registered-output effect on the 3rd posedge clk after the change.
REQ-015 START: synchronized sda falls while synchronized scl is high; in any state, go to ADDR with bit count 0.
REQ-016 STOP: synchronized sda rises while synchronized scl is high; in any state, go to IDLE and release sda_oe; pulse frame_end only if busy was 1.
REQ-017 Data bits SHALL be sampled on the scl rising edge and shifted in MSB first; a 4-bit counter tracks bits 0..8.
REQ-018 States: IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK, IGNORE.
REQ-019 ADDR: after 8 bits, if bits[7:1]==ADDR and R/W==0, go to ADDR_ACK and set busy; otherwise go to IGNORE with no ACK.
REQ-020 ACK: on the scl falling edge after the 8th bit, set sda_oe=1; on the next scl falling edge (end of the 9th clock), clear sda_oe.
REQ-021 IGNORE: sda_oe stays 0 and bus activity is ignored until START or STOP.
REQ-022 CTRL: the byte latches Co=bit7 and DC=bit6; the ACK is given, then go to DATA.
REQ-023 DATA: after 8 bits, pulse byte_valid with byte_data = shifted byte and byte_dcn = latched DC; the pulse is 1 cycle after the 8th scl rising edge is detected; ACK is given.
REQ-024 After DATA_ACK: if Co==0, the next byte is DATA (continuous stream until STOP); if Co==1, the next byte is CTRL.
REQ-025 SDA changes while scl is high, other than START/STOP, SHALL not occur in legal traffic; no other glitch handling is required.
REQ-026 Correct operation SHALL be guaranteed for SCL phases >= MIN_PHASE clk cycles.
REQ-027 STOP or START mid-byte SHALL discard the partial byte, with no byte_valid pulse.
REQ-028 If START and byte completion are detected in the same cycle, START wins and no byte_valid pulse is produced.

Reset
REQ-029 While rst is high at a posedge: state=IDLE; sda_oe, byte_valid, busy, frame_end=0; byte_data=8'h00; byte_dcn=0; bit counter=0; synchronizer and history flops=1 (idle bus).
REQ-030 Reset mid-transaction SHALL release SDA on the next edge; after reset, nothing SHALL be accepted until a new START.

Verification
REQ-031 START, 0x78, 0x00, 0xAF, STOP -> sda_oe=1 in 3 ACK slots; one byte_valid with 0xAF, byte_dcn=0; one frame_end; busy falls at STOP.
REQ-032 START, 0x78, 0x40, 0x11, 0x22, 0x33, STOP -> three byte_valid pulses 0x11/0x22/0x33, all with byte_dcn=1, each ACKed.
REQ-033 START, 0x78, 0x80, 0xA5, 0xC0, 0x5A, STOP -> 0xA5 with dcn=0, then 0x5A with dcn=1; 4 bytes ACKed after the address.
REQ-034 START, 0x7A, 0x00, STOP, and separately START, 0x79 -> sda_oe never 1; no byte_valid, busy, or frame_end.
REQ-035 rst pulsed after 4 data bits of 0xAF -> outputs reset, no pulse; the rest of the bits are ignored; a following full REQ-031 sequence passes.
REQ-036 Repeated START after 3 bits of a DATA byte, then 0x78, 0x00, 0x3C, STOP -> no pulse for the partial byte; one byte_valid with 0x3C, dcn=0.

Source files
------------

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver for an SSD1306-style control/data byte stream.
// Latency: pin change to registered output in 3 clk; no backpressure, byte_valid is a pulse the sink must take.
`timescale 1ns/1ps
module i2c_target_rx #(
   parameter logic [6:0] ADDR      = 7'h3C,
   parameter int         MIN_PHASE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda,
   output logic       sda_oe,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_dcn,
   output logic       busy,
   output logic       frame_end
);

   // ACK must be driven inside the SCL low phase that follows the 8th bit.
   generate
      if (MIN_PHASE < 3) begin : g_phase_check
         $error("i2c_target_rx: MIN_PHASE must be at least 3 clk cycles");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_CTRL,
      S_CTRL_ACK,
      S_DATA,
      S_DATA_ACK,
      S_IGNORE
   } state_t;

   state_t     state;
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   logic       co;
   logic       dc;

   logic scl_meta, scl_s, scl_d;
   logic sda_meta, sda_s, sda_d;

   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic       last_bit;
   logic [7:0] shift_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_meta <= 1'b1;
         scl_s    <= 1'b1;
         scl_d    <= 1'b1;
         sda_meta <= 1'b1;
         sda_s    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_meta <= scl;
         scl_s    <= scl_meta;
         scl_d    <= scl_s;
         sda_meta <= sda;
         sda_s    <= sda_meta;
         sda_d    <= sda_s;
      end
   end

   // START/STOP require SCL stable high across the SDA edge.
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & ~sda_s & sda_d;
   assign stop_det  = scl_s & scl_d & sda_s & ~sda_d;
   assign shift_in  = {shreg[6:0], sda_s};
   assign last_bit  = scl_rise && (bit_cnt == 4'd7);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         bit_cnt    <= 4'd0;
         shreg      <= 8'h00;
         co         <= 1'b0;
         dc         <= 1'b0;
         sda_oe     <= 1'b0;
         byte_valid <= 1'b0;
         byte_data  <= 8'h00;
         byte_dcn   <= 1'b0;
         busy       <= 1'b0;
         frame_end  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_end  <= 1'b0;
         if (start_det) begin
            state   <= S_ADDR;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
         end else if (stop_det) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            frame_end <= busy;
         end else begin
            case (state)
               S_ADDR, S_CTRL, S_DATA: begin
                  if (scl_rise) begin
                     shreg   <= shift_in;
                     bit_cnt <= bit_cnt + 4'd1;
                  end
                  if (last_bit) begin
                     if (state == S_ADDR) begin
                        if (shift_in[7:1] == ADDR && !shift_in[0]) begin
                           state <= S_ADDR_ACK;
                           busy  <= 1'b1;
                        end else begin
                           state <= S_IGNORE;
                        end
                     end else if (state == S_CTRL) begin
                        co    <= shift_in[7];
                        dc    <= shift_in[6];
                        state <= S_CTRL_ACK;
                     end else begin
                        byte_valid <= 1'b1;
                        byte_data  <= shift_in;
                        byte_dcn   <= dc;
                        state      <= S_DATA_ACK;
                     end
                  end
               end
               S_ADDR_ACK, S_CTRL_ACK, S_DATA_ACK: begin
                  // First SCL fall opens the ACK slot, the second closes it.
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                     end else begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        if (state == S_ADDR_ACK)
                           state <= S_CTRL;
                        else if (state == S_CTRL_ACK)
                           state <= S_DATA;
                        else if (co)
                           state <= S_CTRL;
                        else
                           state <= S_DATA;
                     end
                  end
               end
               S_IDLE, S_IGNORE: begin
                  sda_oe <= 1'b0;
               end
               default: begin
                  state  <= S_IDLE;
                  sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bus-master driven bench for i2c_target_rx with an event scoreboard.
`timescale 1ns/1ps
module tb_i2c_target_rx;
   localparam int MIN_PHASE = 4;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe, byte_valid, byte_dcn, busy, frame_end;
   logic [7:0] byte_data;

   int total = 0;
   int bad   = 0;
   int phase = 6;

   typedef enum int {EV_BYTE, EV_ACK, EV_FEND} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] d;
      logic       dcn;
   } ev_t;
   ev_t  exp_q[$];
   logic oe_prev = 1'b0;

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target_rx #(.ADDR(7'h3C), .MIN_PHASE(MIN_PHASE)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl_m),
      .sda       (sda_line),
      .sda_oe    (sda_oe),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_dcn  (byte_dcn),
      .busy      (busy),
      .frame_end (frame_end)
   );

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input logic [7:0] d, input logic dcn);
      ev_t e;
      e.kind = k;
      e.d    = d;
      e.dcn  = dcn;
      exp_q.push_back(e);
   endtask

   task automatic got_ev(input ev_kind_t k, input logic [7:0] d, input logic dcn);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_%s: got data=%02h dcn=%0b, expected no event", k.name(), d, dcn);
         return;
      end
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_BYTE && (e.d != d || e.dcn != dcn))) begin
         bad++;
         $display("FAIL event_%s: got %s data=%02h dcn=%0b expected %s data=%02h dcn=%0b",
                  e.kind.name(), k.name(), d, dcn, e.kind.name(), e.d, e.dcn);
      end
   endtask

   // Monitor: every output event must match the head of the expected queue.
   always @(negedge clk) begin
      if (byte_valid) got_ev(EV_BYTE, byte_data, byte_dcn);
      if (sda_oe && !oe_prev) got_ev(EV_ACK, 8'h00, 1'b0);
      if (frame_end) got_ev(EV_FEND, 8'h00, 1'b0);
      oe_prev = sda_oe;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, expected finish before 1ms");
      $fatal(1, "timeout");
   end

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      clocks(phase / 2);
      scl_m = 1'b1;
      clocks(phase);
      sda_m = 1'b0;
      clocks(phase);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      clocks(phase / 2);
      scl_m = 1'b1;
      clocks(phase);
      sda_m = 1'b1;
      clocks(phase);
   endtask

   task automatic send_bit(input logic b);
      clocks(phase / 2);
      sda_m = b;
      clocks(phase - phase / 2);
      scl_m = 1'b1;
      clocks(phase);
      scl_m = 1'b0;
   endtask

   // Eight bits MSB first, then a released 9th clock where the ACK is sampled.
   task automatic send_byte(input logic [7:0] b, input logic ack, input string name);
      if (ack) expect_ev(EV_ACK, 8'h00, 1'b0);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      clocks(phase / 2);
      sda_m = 1'b1;
      clocks(phase - phase / 2);
      scl_m = 1'b1;
      clocks(phase / 2);
      check({name, "_ack"}, sda_oe, ack);
      clocks(phase - phase / 2);
      scl_m = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] b, input logic dcn, input string name);
      expect_ev(EV_BYTE, b, dcn);
      send_byte(b, 1'b1, name);
   endtask

   task automatic basic_frame(input string name);
      i2c_start();
      send_byte(8'h78, 1'b1, {name, "_addr"});
      check({name, "_busy_on"}, busy, 1);
      send_byte(8'h00, 1'b1, {name, "_ctrl"});
      send_data(8'hAF, 1'b0, {name, "_data"});
      expect_ev(EV_FEND, 8'h00, 1'b0);
      i2c_stop();
      check({name, "_busy_off"}, busy, 0);
      check({name, "_oe_off"}, sda_oe, 0);
      check({name, "_hold"}, byte_data, 8'hAF);
   endtask

   initial begin
      rst = 1'b1;
      clocks(4);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_byte_valid", byte_valid, 0);
      check("rst_byte_data", byte_data, 8'h00);
      check("rst_byte_dcn", byte_dcn, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_end", frame_end, 0);
      rst = 1'b0;
      clocks(4);

      // single command-stream data byte
      basic_frame("t1");

      // continuous data stream, DC=1
      i2c_start();
      send_byte(8'h78, 1'b1, "t2_addr");
      send_byte(8'h40, 1'b1, "t2_ctrl");
      send_data(8'h11, 1'b1, "t2_d0");
      send_data(8'h22, 1'b1, "t2_d1");
      send_data(8'h33, 1'b1, "t2_d2");
      expect_ev(EV_FEND, 8'h00, 1'b0);
      i2c_stop();
      check("t2_busy_off", busy, 0);

      // Co=1 alternation at the minimum phase
      phase = MIN_PHASE;
      i2c_start();
      send_byte(8'h78, 1'b1, "t3_addr");
      send_byte(8'h80, 1'b1, "t3_ctrl0");
      send_data(8'hA5, 1'b0, "t3_d0");
      send_byte(8'hC0, 1'b1, "t3_ctrl1");
      send_data(8'h5A, 1'b1, "t3_d1");
      expect_ev(EV_FEND, 8'h00, 1'b0);
      i2c_stop();
      check("t3_busy_off", busy, 0);
      phase = 6;

      // wrong address, then read request to our address
      i2c_start();
      send_byte(8'h7A, 1'b0, "t4_addr");
      check("t4_busy", busy, 0);
      send_byte(8'h00, 1'b0, "t4_ctrl");
      i2c_stop();
      i2c_start();
      send_byte(8'h79, 1'b0, "t4_read");
      check("t4_read_busy", busy, 0);
      i2c_stop();

      // reset in the middle of a data byte
      i2c_start();
      send_byte(8'h78, 1'b1, "t5_addr");
      send_byte(8'h00, 1'b1, "t5_ctrl");
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rst = 1'b1;
      clocks(2);
      check("t5_rst_oe", sda_oe, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_valid", byte_valid, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      send_bit(1'b1);
      check("t5_tail_oe", sda_oe, 0);
      i2c_stop();
      check("t5_busy_off", busy, 0);
      basic_frame("t5_after");

      // repeated START discards a partial data byte
      i2c_start();
      send_byte(8'h78, 1'b1, "t6_addr0");
      send_byte(8'h00, 1'b1, "t6_ctrl0");
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      i2c_start();
      check("t6_rstart_busy", busy, 0);
      send_byte(8'h78, 1'b1, "t6_addr1");
      send_byte(8'h00, 1'b1, "t6_ctrl1");
      send_data(8'h3C, 1'b0, "t6_data");
      expect_ev(EV_FEND, 8'h00, 1'b0);
      i2c_stop();
      check("t6_busy_off", busy, 0);

      clocks(20);
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
